// File: rtl/velocidade_pkg.sv
// Shared types for the speed controller: FSM states, level codes
// and the level-to-duty table used by the PWM generator.
package velocidade_pkg;

    typedef enum logic [2:0] {
        PARADO,
        ACELERANDO,
        CRUZEIRO,
        DESACELERANDO,
        BLOQUEADO
    } estado_t;

    // Codes are ordered so that unsigned compare gives level order
    typedef logic [1:0] nivel_t;

    localparam nivel_t NIVEL_0 = 2'b00;
    localparam nivel_t NIVEL_2 = 2'b01;
    localparam nivel_t NIVEL_4 = 2'b10;
    localparam nivel_t NIVEL_8 = 2'b11;

    localparam int DUTY_W = 4;

    function automatic logic [DUTY_W-1:0] duty_de(input nivel_t n);
        logic [DUTY_W-1:0] d;
        d = 4'd0;
        unique case (1'b1)
            (n == NIVEL_0): d = 4'd0;
            (n == NIVEL_2): d = 4'd2;
            (n == NIVEL_4): d = 4'd4;
            (n == NIVEL_8): d = 4'd8;
            default:        d = 4'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/controle_velocidade_if.sv
// Switch, obstacle and status bundle between the controller
// and its surroundings.
interface controle_velocidade_if;

    logic chave1;
    logic chave2;
    logic obstaculo;
    logic vel_chave1;
    logic vel_chave2;
    logic pwm;
    logic em_rampa;
    logic bloqueado;

    modport master (
        output chave1, chave2, obstaculo,
        input  vel_chave1, vel_chave2, pwm,
        input  em_rampa, bloqueado
    );

    modport slave (
        input  chave1, chave2, obstaculo,
        output vel_chave1, vel_chave2, pwm,
        output em_rampa, bloqueado
    );

endinterface

// File: rtl/gerador_pwm.sv
// Free-running 3-bit PWM: output high while cnt < duty,
// so duty 8 keeps the motor fully on.
module gerador_pwm
    import velocidade_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm
);

    logic [2:0] cnt;

    // Period counter and registered comparator
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= 3'd0;
            pwm <= 1'b0;
        end else begin
            cnt <= cnt + 3'd1;
            pwm <= ({1'b0, cnt} < duty);
        end
    end

endmodule

// File: rtl/controle_velocidade.sv
// Speed controller: ramps the motor level toward the switch
// setting one step per PASSO_CICLOS, with emergency lockout.
module controle_velocidade
    import velocidade_pkg::*;
#(
    parameter int PASSO_CICLOS = 50000000
) (
    input  logic                  clock,
    input  logic                  reset,
    controle_velocidade_if.slave  bus
);

    localparam int TW = $clog2(PASSO_CICLOS);
    localparam logic [TW-1:0] TMR_FIM = TW'(PASSO_CICLOS - 1);

    logic [2:0]    s1;
    logic [2:0]    s2;
    nivel_t        alvo;
    logic          obst_s;

    estado_t       st;
    estado_t       st_n;
    nivel_t        lvl;
    nivel_t        lvl_n;
    nivel_t        prox;
    nivel_t        vel_q;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_n;
    logic          fim;
    logic          pwm_w;

    // Two-flop synchronizers for the asynchronous switches
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= 3'b000;
            s2 <= 3'b000;
        end else begin
            s1 <= {bus.chave1, bus.chave2, bus.obstaculo};
            s2 <= s1;
        end
    end

    assign alvo   = s2[2:1];
    assign obst_s = s2[0];
    assign fim    = (tmr == TMR_FIM);

    // State, level, step timer and display copy of the level
    always_ff @(posedge clock) begin
        if (reset) begin
            st    <= PARADO;
            lvl   <= NIVEL_0;
            tmr   <= '0;
            vel_q <= NIVEL_0;
        end else begin
            st    <= st_n;
            lvl   <= lvl_n;
            tmr   <= tmr_n;
            vel_q <= lvl_n;
        end
    end

    // Next state: obstacle first, then ramp toward alvo
    always_comb begin
        st_n  = st;
        lvl_n = lvl;
        tmr_n = tmr;
        prox  = lvl;
        if (obst_s) begin
            st_n  = BLOQUEADO;
            lvl_n = NIVEL_0;
            tmr_n = '0;
        end else begin
            unique case (st)
                PARADO, CRUZEIRO: begin
                    tmr_n = '0;
                    if (alvo > lvl) begin
                        st_n = ACELERANDO;
                    end else if (alvo < lvl) begin
                        st_n = DESACELERANDO;
                    end
                end
                ACELERANDO: begin
                    if (alvo < lvl) begin
                        st_n  = DESACELERANDO;
                        tmr_n = '0;
                    end else if (alvo == lvl) begin
                        st_n  = (lvl == NIVEL_0) ? PARADO : CRUZEIRO;
                        tmr_n = '0;
                    end else if (fim) begin
                        prox  = lvl + 2'd1;
                        lvl_n = prox;
                        tmr_n = '0;
                        if (prox == alvo) begin
                            st_n = CRUZEIRO;
                        end
                    end else begin
                        tmr_n = tmr + 1'b1;
                    end
                end
                DESACELERANDO: begin
                    if (alvo > lvl) begin
                        st_n  = ACELERANDO;
                        tmr_n = '0;
                    end else if (alvo == lvl) begin
                        st_n  = (lvl == NIVEL_0) ? PARADO : CRUZEIRO;
                        tmr_n = '0;
                    end else if (fim) begin
                        prox  = lvl - 2'd1;
                        lvl_n = prox;
                        tmr_n = '0;
                        if (prox == alvo) begin
                            st_n = (prox == NIVEL_0) ? PARADO : CRUZEIRO;
                        end
                    end else begin
                        tmr_n = tmr + 1'b1;
                    end
                end
                BLOQUEADO: begin
                    lvl_n = NIVEL_0;
                    tmr_n = '0;
                    if (alvo == NIVEL_0) begin
                        st_n = PARADO;
                    end
                end
                default: begin
                    st_n  = PARADO;
                    lvl_n = NIVEL_0;
                    tmr_n = '0;
                end
            endcase
        end
    end

    gerador_pwm u_pwm (
        .clock (clock),
        .reset (reset),
        .duty  (duty_de(lvl)),
        .pwm   (pwm_w)
    );

    assign bus.vel_chave1 = vel_q[1];
    assign bus.vel_chave2 = vel_q[0];
    assign bus.pwm        = pwm_w;
    assign bus.em_rampa   = (st == ACELERANDO) || (st == DESACELERANDO);
    assign bus.bloqueado  = (st == BLOQUEADO);

endmodule

// File: tb/tb_controle_velocidade.sv
// Bench for controle_velocidade: directed scenarios plus random
// switch traffic checked against a level/ramp reference model.
module tb_controle_velocidade;

    localparam int P = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;

    controle_velocidade_if vif ();

    controle_velocidade #(.PASSO_CICLOS(P)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (vif.slave)
    );

    always #5 clock = ~clock;

    // Reference model: integer level, ramp direction, elapsed cycles
    int         m_lvl = 0;
    int         m_dir = 0;
    int         m_el  = 0;
    int         m_cnt = 0;
    logic       m_blk = 1'b0;
    logic       m_pwm = 1'b0;
    logic [2:0] hist[$] = '{3'b000, 3'b000};
    int         duty_tab[4] = '{0, 2, 4, 8};

    task automatic modelo();
        logic [2:0] cur;
        int alvo;
        int d;
        if (reset) begin
            m_lvl = 0; m_dir = 0; m_el = 0; m_cnt = 0;
            m_blk = 1'b0; m_pwm = 1'b0;
            hist = '{3'b000, 3'b000};
        end else begin
            cur = hist.pop_front();
            hist.push_back({vif.chave1, vif.chave2, vif.obstaculo});
            alvo = int'(cur[2:1]);
            m_pwm = (m_cnt < duty_tab[m_lvl]);
            m_cnt = (m_cnt + 1) % 8;
            if (cur[0]) begin
                m_blk = 1'b1; m_lvl = 0; m_dir = 0; m_el = 0;
            end else if (m_blk) begin
                if (alvo == 0) m_blk = 1'b0;
            end else begin
                d = (alvo > m_lvl) ? 1 : (alvo < m_lvl) ? -1 : 0;
                if (d == 0) begin
                    m_dir = 0; m_el = 0;
                end else if (d != m_dir) begin
                    m_dir = d; m_el = 0;
                end else begin
                    m_el++;
                    if (m_el == P) begin
                        m_lvl = m_lvl + d;
                        m_el = 0;
                        if (m_lvl == alvo) m_dir = 0;
                    end
                end
            end
        end
    endtask

    always @(posedge clock) modelo();

    logic [4:0] obs;
    logic [4:0] expv;
    assign obs  = {vif.vel_chave1, vif.vel_chave2, vif.pwm,
                   vif.em_rampa, vif.bloqueado};
    assign expv = {m_lvl[1:0], m_pwm, (m_dir != 0), m_blk};

    task automatic chaves(input logic [1:0] c);
        vif.chave1 = c[1];
        vif.chave2 = c[0];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        chaves(2'b00);
        vif.obstaculo = 1'b0;
        repeat (3) @(negedge clock);
        n_vec++;
        if (obs !== 5'b00000) begin
            n_miss++;
            $display("FAIL reset: got %b want 00000", obs);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            n_vec++;
            if (obs !== expv || vif.pwm !== 1'b0) begin
                n_miss++;
                $display("FAIL idle cyc %0d: got %b want %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_acelera();
        int rise = 0;
        chaves(2'b11);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL acel cyc %0d: got %b want %b", i, obs, expv);
            end
            if (rise == 0 && vif.em_rampa === 1'b1) rise = i;
        end
        n_vec++;
        if (rise != 3) begin
            n_miss++;
            $display("FAIL acel_latency: got %0d want 3", rise);
        end
        n_vec++;
        if (obs[4:3] !== 2'b11 || vif.em_rampa !== 1'b0) begin
            n_miss++;
            $display("FAIL acel_final: got %b want 11x00", obs);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            n_vec++;
            if (vif.pwm !== 1'b1) begin
                n_miss++;
                $display("FAIL pwm_full cyc %0d: got %b want 1", i, vif.pwm);
            end
        end
    endtask

    task automatic test_desacela();
        int altos = 0;
        chaves(2'b01);
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL desac cyc %0d: got %b want %b", i, obs, expv);
            end
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (vif.pwm === 1'b1) altos++;
        end
        n_vec++;
        if (altos != 2 || obs[4:3] !== 2'b01) begin
            n_miss++;
            $display("FAIL pwm_quarter: got %0d highs code %b want 2 01",
                     altos, obs[4:3]);
        end
    endtask

    task automatic test_reversao();
        int ok = 0;
        chaves(2'b00);
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL rev_pre cyc %0d: got %b want %b", i, obs, expv);
            end
        end
        chaves(2'b11);
        for (int i = 0; i < 20 && ok == 0; i++) begin
            @(negedge clock);
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL rev_up cyc %0d: got %b want %b", i, obs, expv);
            end
            if (obs[4:3] === 2'b01) ok = 1;
        end
        n_vec++;
        if (ok == 0) begin
            n_miss++;
            $display("FAIL rev_timeout: got no level 01 want 01");
        end
        chaves(2'b00);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL rev_down cyc %0d: got %b want %b", i, obs, expv);
            end
        end
        n_vec++;
        if (obs !== 5'b00000) begin
            n_miss++;
            $display("FAIL rev_final: got %b want 00000", obs);
        end
    endtask

    task automatic test_obstaculo();
        chaves(2'b10);
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL obst_pre cyc %0d: got %b want %b", i, obs, expv);
            end
        end
        vif.obstaculo = 1'b1;
        @(negedge clock);
        vif.obstaculo = 1'b0;
        @(negedge clock);
        @(negedge clock);
        n_vec++;
        if (obs[4:3] !== 2'b00 || vif.bloqueado !== 1'b1) begin
            n_miss++;
            $display("FAIL obst_stop: got %b want 00xx1", obs);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_vec++;
            if (obs !== expv || vif.bloqueado !== 1'b1) begin
                n_miss++;
                $display("FAIL obst_hold cyc %0d: got %b want %b", i, obs, expv);
            end
        end
        chaves(2'b00);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL obst_exit cyc %0d: got %b want %b", i, obs, expv);
            end
        end
        n_vec++;
        if (obs !== 5'b00000) begin
            n_miss++;
            $display("FAIL obst_final: got %b want 00000", obs);
        end
    endtask

    task automatic test_reset_rampa();
        int ok = 0;
        chaves(2'b11);
        for (int i = 0; i < 20 && ok == 0; i++) begin
            @(negedge clock);
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL rst_ramp cyc %0d: got %b want %b", i, obs, expv);
            end
            if (obs[4:3] === 2'b01 && vif.em_rampa === 1'b1) ok = 1;
        end
        n_vec++;
        if (ok == 0) begin
            n_miss++;
            $display("FAIL rst_timeout: got no ramp at 01 want 01");
        end
        reset = 1'b1;
        @(negedge clock);
        n_vec++;
        if (obs !== 5'b00000) begin
            n_miss++;
            $display("FAIL rst_mid: got %b want 00000", obs);
        end
        reset = 1'b0;
        chaves(2'b00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL rst_after cyc %0d: got %b want %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            @(negedge clock);
            n_vec++;
            if (obs !== expv) begin
                n_miss++;
                $display("FAIL rand cyc %0d: got %b want %b", i, obs, expv);
            end
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) == 0) chaves(2'($urandom_range(0, 3)));
            vif.obstaculo = ($urandom_range(0, 39) == 0);
        end
        reset = 1'b0;
        vif.obstaculo = 1'b0;
    endtask

    initial begin
        chaves(2'b00);
        vif.obstaculo = 1'b0;
        test_reset();
        test_acelera();
        test_desacela();
        test_reversao();
        test_obstaculo();
        test_reset_rampa();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
